// File: rtl/nibble_pack_if.sv
// Nibble stream in, two word banks out, each with its own valid/ready pair.
interface nibble_pack_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            DATA_IN;
  logic                  VALID_IN;
  logic                  READY_IN;
  logic                  FLUSH;
  logic [3:0]            NIBBLE_CNT;
  logic [DATA_WIDTH-1:0] DATA_A;
  logic                  VALID_A;
  logic                  READY_A;
  logic [DATA_WIDTH-1:0] DATA_B;
  logic                  VALID_B;
  logic                  READY_B;

  // Source of nibbles and consumer of both banks.
  modport master (
    output DATA_IN, VALID_IN, FLUSH, READY_A, READY_B,
    input  READY_IN, NIBBLE_CNT, DATA_A, VALID_A, DATA_B, VALID_B
  );

  // The packer itself.
  modport slave (
    input  DATA_IN, VALID_IN, FLUSH, READY_A, READY_B,
    output READY_IN, NIBBLE_CNT, DATA_A, VALID_A, DATA_B, VALID_B
  );
endinterface

// File: rtl/nibble_pack.sv
// Rebuilds DATA_WIDTH-bit words from a 4-bit nibble stream, most-significant
// nibble first, and hands completed words to banks A and B in strict
// alternation. A word that cannot be delivered parks in HOLD until its bank frees.
module nibble_pack #(
  parameter int NIBBLES    = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  nibble_pack_if.slave  bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q;
  logic                  ptr_q;      // 0: next word goes to A, 1: to B
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] data_a_q;
  logic [DATA_WIDTH-1:0] data_b_q;
  logic                  vld_a_q;
  logic                  vld_b_q;

  logic                  ready_in;
  logic                  accept;
  logic [3:0]            cnt_inc;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  complete;
  logic                  tgt_free;
  logic                  load;
  logic                  load_a;
  logic                  load_b;

  // State decode; masked while RESET is high so nothing is taken mid-clear.
  assign ready_in = (state_q == FILL) && !RESET;
  assign accept   = bus.VALID_IN && ready_in;
  assign cnt_inc  = cnt_q + {3'b000, accept};

  // Drop an accepted nibble into its slot; unfilled low nibbles stay zero.
  always_comb begin
    word_nxt = shreg_q;
    for (int k = 0; k < NIBBLES; k++) begin
      if (accept && (cnt_q == 4'(k)))
        word_nxt[DATA_WIDTH-1-4*k -: 4] = bus.DATA_IN;
    end
  end

  // A nibble arriving with FLUSH joins the word before it closes.
  assign complete = (state_q == FILL) &&
                    ((accept && (cnt_q == 4'(NIBBLES-1))) ||
                     (bus.FLUSH && (cnt_inc != 4'd0)));

  // Target bank is free if empty or being drained on this same edge.
  assign tgt_free = ptr_q ? (!vld_b_q || bus.READY_B)
                          : (!vld_a_q || bus.READY_A);
  assign load     = (complete || (state_q == HOLD)) && tgt_free;
  assign load_a   = load && !ptr_q;
  assign load_b   = load &&  ptr_q;

  // FSM, assembly register, counter and both output banks.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FILL;
      ptr_q    <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= 4'd0;
      data_a_q <= '0;
      data_b_q <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL:    if (complete && !tgt_free) state_q <= HOLD;
        HOLD:    if (tgt_free)              state_q <= FILL;
        default:                            state_q <= FILL;
      endcase

      // While a word is parked the counter freezes with it.
      if (load) begin
        shreg_q <= '0;
        cnt_q   <= 4'd0;
        ptr_q   <= ~ptr_q;
      end else if (complete) begin
        shreg_q <= word_nxt;
      end else if (accept) begin
        shreg_q <= word_nxt;
        cnt_q   <= cnt_inc;
      end

      // A fresh load wins over a same-edge drain, keeping VALID high.
      if (load_a) begin
        data_a_q <= word_nxt;
        vld_a_q  <= 1'b1;
      end else if (vld_a_q && bus.READY_A) begin
        vld_a_q  <= 1'b0;
      end

      if (load_b) begin
        data_b_q <= word_nxt;
        vld_b_q  <= 1'b1;
      end else if (vld_b_q && bus.READY_B) begin
        vld_b_q  <= 1'b0;
      end
    end
  end

  assign bus.READY_IN   = ready_in;
  assign bus.NIBBLE_CNT = cnt_q;
  assign bus.DATA_A     = data_a_q;
  assign bus.VALID_A    = vld_a_q;
  assign bus.DATA_B     = data_b_q;
  assign bus.VALID_B    = vld_b_q;

endmodule

// File: tb/tb_nibble_pack.sv
// Directed vector table for nibble_pack plus a randomised two-bank scoreboard run.
module tb_nibble_pack;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  nibble_pack_if #(.DATA_WIDTH(32)) bus ();

  nibble_pack #(.NIBBLES(8), .DATA_WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v, f, ra, rb;
    logic [3:0]  n;
    logic        rdy;
    logic [3:0]  cnt;
    logic        va, vb;
    logic [31:0] da, db;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  bit          drv_done = 1'b0;
  int          n_cons   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst_i, input logic v, input logic f, input logic ra,
                     input logic rb, input logic [3:0] n, input logic rdy,
                     input logic [3:0] cnt, input logic va, input logic vb,
                     input logic [31:0] da, input logic [31:0] db);
    vec_t r;
    r.rst = rst_i; r.v = v; r.f = f; r.ra = ra; r.rb = rb; r.n = n;
    r.rdy = rdy; r.cnt = cnt; r.va = va; r.vb = vb; r.da = da; r.db = db;
    vecs.push_back(r);
  endtask

  // Offer one nibble until accepted, with a bounded wait.
  task automatic send(input logic [3:0] nb, input logic fl);
    int   b;
    logic r;
    b = 0;
    bus.DATA_IN  = nb;
    bus.VALID_IN = 1'b1;
    bus.FLUSH    = fl;
    forever begin
      r = bus.READY_IN;
      tick();
      if (r) break;
      b++;
      if (b > 500) begin
        checks++;
        errors++;
        $display("FAIL send timeout: got no accept expected accept within 500 cycles");
        break;
      end
    end
  endtask

  initial begin
    // Test 1: eight nibbles into A, consumer ready
    for (int k = 1; k <= 7; k++) add(0,1,0,1,0,4'(k), 1,4'(k),0,0, 32'h0,32'h0);
    add(0,1,0,1,0,4'd8, 1,4'd0,1,0, 32'h12345678,32'h0);
    add(0,0,0,1,0,4'd0, 1,4'd0,0,0, 32'h12345678,32'h0);
    // Test 2: both banks stalled, third word parks in HOLD
    add(1,0,0,0,0,4'd0, 0,4'd0,0,0, 32'h0,32'h0);
    for (int k = 0; k <= 6; k++) add(0,1,0,0,0,4'(k), 1,4'(k+1),0,0, 32'h0,32'h0);
    add(0,1,0,0,0,4'd7, 1,4'd0,1,0, 32'h01234567,32'h0);
    for (int k = 8; k <= 14; k++) add(0,1,0,0,0,4'(k), 1,4'(k-7),1,0, 32'h01234567,32'h0);
    add(0,1,0,0,0,4'hF, 1,4'd0,1,1, 32'h01234567,32'h89ABCDEF);
    for (int k = 1; k <= 7; k++) add(0,1,0,0,0,4'(k), 1,4'(k),1,1, 32'h01234567,32'h89ABCDEF);
    add(0,1,0,0,0,4'd8, 0,4'd7,1,1, 32'h01234567,32'h89ABCDEF);
    add(0,1,0,0,0,4'd9, 0,4'd7,1,1, 32'h01234567,32'h89ABCDEF);
    add(0,0,0,1,0,4'd0, 1,4'd0,1,1, 32'h12345678,32'h89ABCDEF);
    // Test 3: A,B,C then FLUSH alone into B; FLUSH at count 0 ignored
    add(0,1,0,0,1,4'hA, 1,4'd1,1,0, 32'h12345678,32'h89ABCDEF);
    add(0,1,0,0,0,4'hB, 1,4'd2,1,0, 32'h12345678,32'h89ABCDEF);
    add(0,1,0,0,0,4'hC, 1,4'd3,1,0, 32'h12345678,32'h89ABCDEF);
    add(0,0,1,0,0,4'd0, 1,4'd0,1,1, 32'h12345678,32'hABC00000);
    add(0,0,1,0,0,4'd0, 1,4'd0,1,1, 32'h12345678,32'hABC00000);
    // Test 4: FLUSH on eighth nibble, then FLUSH on nibble 3
    add(0,1,0,1,0,4'hF, 1,4'd1,0,1, 32'h12345678,32'hABC00000);
    for (int k = 0; k < 6; k++) add(0,1,0,0,0,4'(14-k), 1,4'(k+2),0,1, 32'h12345678,32'hABC00000);
    add(0,1,1,0,0,4'h8, 1,4'd0,1,1, 32'hFEDCBA98,32'hABC00000);
    add(0,0,1,0,0,4'd0, 1,4'd0,1,1, 32'hFEDCBA98,32'hABC00000);
    add(0,1,0,0,1,4'h5, 1,4'd1,1,0, 32'hFEDCBA98,32'hABC00000);
    add(0,1,0,0,0,4'h6, 1,4'd2,1,0, 32'hFEDCBA98,32'hABC00000);
    add(0,1,1,0,0,4'h7, 1,4'd0,1,1, 32'hFEDCBA98,32'h56700000);
    // Test 6: reset after 5 nibbles with both banks full, then a word into A
    for (int k = 1; k <= 5; k++) add(0,1,0,0,0,4'(k), 1,4'(k),1,1, 32'hFEDCBA98,32'h56700000);
    add(1,1,0,0,0,4'd6, 0,4'd0,0,0, 32'h0,32'h0);
    for (int k = 0; k < 7; k++) add(0,1,0,0,0,4'(9+k), 1,4'(k+1),0,0, 32'h0,32'h0);
    add(0,1,0,0,0,4'h0, 1,4'd0,1,0, 32'h9ABCDEF0,32'h0);

    // Initial reset
    rst = 1'b1;
    bus.DATA_IN = 4'd0; bus.VALID_IN = 1'b0; bus.FLUSH = 1'b0;
    bus.READY_A = 1'b0; bus.READY_B = 1'b0;
    tick();
    tick();
    chk("reset ready_in",  32'(bus.READY_IN),   32'd0);
    chk("reset cnt",       32'(bus.NIBBLE_CNT), 32'd0);
    chk("reset valid_a",   32'(bus.VALID_A),    32'd0);
    chk("reset valid_b",   32'(bus.VALID_B),    32'd0);
    chk("reset data_a",    bus.DATA_A,          32'd0);
    chk("reset data_b",    bus.DATA_B,          32'd0);
    rst = 1'b0;
    #1;
    chk("ready_in after reset falls", 32'(bus.READY_IN), 32'd1);

    // Table run
    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      bus.VALID_IN = vecs[i].v;
      bus.FLUSH    = vecs[i].f;
      bus.DATA_IN  = vecs[i].n;
      bus.READY_A  = vecs[i].ra;
      bus.READY_B  = vecs[i].rb;
      tick();
      chk($sformatf("row%0d ready_in", i), 32'(bus.READY_IN),   32'(vecs[i].rdy));
      chk($sformatf("row%0d cnt", i),      32'(bus.NIBBLE_CNT), 32'(vecs[i].cnt));
      chk($sformatf("row%0d valid_a", i),  32'(bus.VALID_A),    32'(vecs[i].va));
      chk($sformatf("row%0d valid_b", i),  32'(bus.VALID_B),    32'(vecs[i].vb));
      chk($sformatf("row%0d data_a", i),   bus.DATA_A,          vecs[i].da);
      chk($sformatf("row%0d data_b", i),   bus.DATA_B,          vecs[i].db);
    end

    // Test 5: random gaps, random lengths with FLUSH, random bank readiness
    rst = 1'b1;
    bus.VALID_IN = 1'b0; bus.FLUSH = 1'b0; bus.READY_A = 1'b0; bus.READY_B = 1'b0;
    tick();
    rst = 1'b0;
    fork
      begin : drv
        bit          bank;
        int          len;
        int          gap;
        logic [3:0]  nb;
        logic [31:0] word;
        bank = 1'b0;
        for (int w = 0; w < 100; w++) begin
          len  = $urandom_range(1, 8);
          word = 32'h0;
          for (int k = 0; k < len; k++) begin
            nb  = 4'($urandom);
            gap = $urandom_range(0, 3);
            bus.VALID_IN = 1'b0;
            bus.FLUSH    = 1'b0;
            repeat (gap) tick();
            word = word | (32'(nb) << (28 - 4*k));
            send(nb, (k == len-1) && (len < 8));
          end
          if (bank) exp_b.push_back(word);
          else      exp_a.push_back(word);
          bank = ~bank;
        end
        bus.VALID_IN = 1'b0;
        bus.FLUSH    = 1'b0;
        drv_done = 1'b1;
      end
      begin : cons
        int guard;
        guard = 0;
        while (!(drv_done && exp_a.size() == 0 && exp_b.size() == 0) && guard < 20000) begin
          @(posedge clk);
          #2;
          guard++;
          bus.READY_A = 1'($urandom_range(0, 1));
          bus.READY_B = 1'($urandom_range(0, 1));
          if (bus.VALID_A && bus.READY_A) begin
            n_cons++;
            if (exp_a.size() == 0) begin
              checks++; errors++;
              $display("FAIL rand bank A: got word 0x%0h expected none", bus.DATA_A);
            end else chk("rand bank A word", bus.DATA_A, exp_a.pop_front());
          end
          if (bus.VALID_B && bus.READY_B) begin
            n_cons++;
            if (exp_b.size() == 0) begin
              checks++; errors++;
              $display("FAIL rand bank B: got word 0x%0h expected none", bus.DATA_B);
            end else chk("rand bank B word", bus.DATA_B, exp_b.pop_front());
          end
        end
        if (guard >= 20000) begin
          checks++; errors++;
          $display("FAIL rand drain timeout: got %0d words expected 100", n_cons);
        end
        @(posedge clk);
        #2;
        bus.READY_A = 1'b0;
        bus.READY_B = 1'b0;
      end
    join
    chk("rand words consumed", 32'(n_cons),      32'd100);
    chk("rand leftover A",     32'(bus.VALID_A), 32'd0);
    chk("rand leftover B",     32'(bus.VALID_B), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_pack.md
Name: nibble_pack

Overview:
- Inverse of the major-nibble selector: takes a 4-bit nibble stream and rebuilds 32-bit words for the DATA_A / DATA_B ports.
- Nibbles are assembled most-significant first in a shift register.
- Completed words are written alternately to two output banks, A then B then A, each with a valid/ready handshake.
- Used as the source stage for DATA_A/DATA_B in loopback tests and as the unpacking side of the nibble datapath.

Parameters:
- NIBBLES, 8, nibbles per word.
- DATA_WIDTH, 32, word width; must equal 4*NIBBLES.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  4  nibble in.
- VALID_IN  input  1  DATA_IN is valid this cycle.
- READY_IN  output  1  packer accepts a nibble this cycle.
- FLUSH  input  1  close the partial word now and pad it with zeros.
- NIBBLE_CNT  output  4  nibbles held in the current partial word (0..NIBBLES-1).
- DATA_A  output  DATA_WIDTH  bank A word.
- VALID_A  output  1  bank A holds an unconsumed word.
- READY_A  input  1  consumer takes bank A.
- DATA_B  output  DATA_WIDTH  bank B word.
- VALID_B  output  1  bank B holds an unconsumed word.
- READY_B  input  1  consumer takes bank B.

Behaviour:
- Reset (synchronous, RESET=1 at an edge):
  - DATA_A, DATA_B, VALID_A, VALID_B, NIBBLE_CNT, shift register = 0.
  - Bank pointer = A; state = FILL.
  - READY_IN = 0 while RESET is high; READY_IN = 1 in the first cycle after RESET falls.
  - Reset mid-word discards the partial word and both banks, no flush.
- Accept: a nibble is accepted when VALID_IN && READY_IN.
  - The k-th accepted nibble (k=0 first) goes to bits [DATA_WIDTH-1-4k -: 4].
  - NIBBLE_CNT increments.
- READY_IN = (state == FILL). It is a registered state decode and is independent of VALID_IN.
- FILL state, word completion:
  - The word is complete when nibble NIBBLES-1 is accepted, or when FLUSH=1 with a nonzero count after this cycle's accept.
  - Unfilled low nibbles are 0.
- FLUSH + VALID_IN in the same cycle: the nibble is included first, then the word closes.
  - If that nibble is the 8th, the word is complete normally with no padding.
- FLUSH with count 0 and no accept: ignored.
- Transfer of a complete word:
  - If the target bank (pointer) is free this cycle (VALID_x=0, or VALID_x && READY_x), then on the next edge: DATA_x = word, VALID_x = 1, pointer toggles, NIBBLE_CNT = 0, state stays FILL.
  - Latency: VALID_x is high 1 cycle after the completing accept.
- If the target bank is busy, state goes to HOLD.
  - READY_IN = 0 and the word is held.
  - Each cycle the target bank becomes free, the transfer happens as above and the state returns to FILL.
- Bank handshake:
  - VALID_x clears on the edge where VALID_x && READY_x, unless a new word is loaded into x on the same edge, in which case VALID_x stays 1 with the new DATA_x.
  - DATA_x is stable while VALID_x=1 and retains its last value after consumption.
- Ordering: banks are filled strictly alternately starting at A. No reordering; a word never skips a busy bank.
- READY_x while VALID_x=0: no effect.
- Maximum throughput: 1 nibble per cycle, with no bubble at word boundaries when the target bank is free.

Test Plan:
1. Release RESET, then 8 consecutive nibbles 1..8 with READY_A=1.
   - Required: DATA_A=0x12345678, VALID_A=1 in the cycle after the 8th accept, cleared on the next edge.
   - Required: READY_IN stays 1 throughout.
2. READY_A=READY_B=0, stream 0x0..0xF, then 8 more nibbles 0x1..0x8.
   - Required: DATA_A=0x01234567, DATA_B=0x89ABCDEF.
   - Required: the third word holds in HOLD with READY_IN=0 and NIBBLE_CNT frozen.
   - Pulse READY_A one cycle: required DATA_A=0x12345678 next cycle, VALID_A stays 1, READY_IN=1.
3. Nibbles A,B,C, then FLUSH alone.
   - Required: 0xABC00000 in the next bank one cycle later, NIBBLE_CNT=0.
   - FLUSH at count 0: required no bank change.
4. FLUSH with VALID_IN on the 8th nibble of 0xFEDCBA98.
   - Required: exactly one word, 0xFEDCBA98, no extra empty word.
   - VALID_IN+FLUSH on nibble 3 of 5,6,7: required 0x56700000.
5. Interleave VALID_IN gaps (random 0-3 idle cycles) and random READY_A/B over 100 words.
   - Required: scoreboard shows words in order, alternating A/B, none lost or duplicated.
6. RESET after 5 nibbles with VALID_B=1.
   - Required: next cycle all outputs 0.
   - Required: the following 8 nibbles land in bank A, not B.
